// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : shared opcode, state, bus-source, register-select and load-strobe
//            encodings for the ALU-class instruction sequencer.
// Revision : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  localparam logic [4:0] c_op_or   = 5'b01011;
  localparam logic [4:0] c_op_and  = 5'b01010;
  localparam logic [4:0] c_op_not  = 5'b10010;
  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_mul  = 5'b01111;
  localparam logic [4:0] c_op_div  = 5'b10000;
  localparam logic [4:0] c_op_shr  = 5'b00101;
  localparam logic [4:0] c_op_shra = 5'b00110;
  localparam logic [4:0] c_op_shl  = 5'b00111;
  localparam logic [4:0] c_op_ror  = 5'b01000;
  localparam logic [4:0] c_op_rol  = 5'b01001;
  localparam logic [4:0] c_op_neg  = 5'b10001;

  localparam logic [2:0] c_bus_none = 3'd0;
  localparam logic [2:0] c_bus_pc   = 3'd1;
  localparam logic [2:0] c_bus_zlo  = 3'd2;
  localparam logic [2:0] c_bus_zhi  = 3'd3;
  localparam logic [2:0] c_bus_mdr  = 3'd4;
  localparam logic [2:0] c_bus_reg  = 3'd5;

  localparam logic [1:0] c_reg_none = 2'd0;
  localparam logic [1:0] c_reg_ra   = 2'd1;
  localparam logic [1:0] c_reg_rb   = 2'd2;
  localparam logic [1:0] c_reg_rc   = 2'd3;

  localparam int c_ld_w   = 9;
  localparam int c_ld_mar = 0;
  localparam int c_ld_z   = 1;
  localparam int c_ld_y   = 2;
  localparam int c_ld_pc  = 3;
  localparam int c_ld_mdr = 4;
  localparam int c_ld_ir  = 5;
  localparam int c_ld_r   = 6;
  localparam int c_ld_lo  = 7;
  localparam int c_ld_hi  = 8;

  function automatic logic op_is_legal(input logic [4:0] op);
    case (op)
      c_op_or, c_op_and, c_op_not, c_op_add, c_op_sub, c_op_mul, c_op_div,
      c_op_shr, c_op_shra, c_op_shl, c_op_ror, c_op_rol, c_op_neg:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == c_op_mul) || (op == c_op_div);
  endfunction

  // Single-operand ops read Rb only and skip the Y/Rc step.
  function automatic logic op_is_unary(input logic [4:0] op);
    return (op == c_op_not) || (op == c_op_neg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_if
// Purpose  : control/handshake bundle between the sequencer (master) and the
//            datapath/IR/memory side (slave). SINGLE_STEP_EN adds step.
// Revision : 1.0  initial release
// ============================================================================
interface alu_seq_ctrl_if #(
  parameter int OP_W = 5
) ();
  import cpu_ctrl_pkg::*;

  logic                run;
  logic [31:0]         ir;
  logic                mem_ready;
  logic                alu_done;
`ifdef SINGLE_STEP_EN
  logic                step;
`endif
  logic [2:0]          bus_src;
  logic [1:0]          reg_sel;
  logic [c_ld_w-1:0]   ld;
  logic                inc_pc;
  logic                mem_read;
  logic [OP_W-1:0]     alu_op;
  logic                alu_start;
  logic                busy;
  logic                instr_done;
  logic                illegal_op;
  logic                timeout;

  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  run, ir, mem_ready, alu_done,
    output bus_src, reg_sel, ld, inc_pc, mem_read, alu_op, alu_start,
    output busy, instr_done, illegal_op, timeout
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output run, ir, mem_ready, alu_done,
    input  bus_src, reg_sel, ld, inc_pc, mem_read, alu_op, alu_start,
    input  busy, instr_done, illegal_op, timeout
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_wait_timer
// Purpose  : wait-state cycle counter shared by the memory and MUL/DIV waits;
//            flags the first wait cycle and the abort cycle (WAIT_MAX-1).
// Revision : 1.0  initial release
// ============================================================================
module ctrl_wait_timer #(
  parameter int WAIT_MAX = 64
) (
  input  logic clock,
  input  logic clear_n,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic expired
);

  localparam int          CW     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] c_last = CW'(WAIT_MAX - 1);

  logic [CW-1:0] r_count;

  // Saturates at the abort value so a stalled enable can never wrap to "first".
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign first   = (r_count == '0);
  assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : multi-cycle T0..T6 control sequencer for the single-bus ALU
//            datapath. Define SINGLE_STEP_EN to add a one-instruction step.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 64,
  parameter int OP_W     = 5
) (
  input  logic              clock,
  input  logic              clear_n,
  alu_seq_ctrl_if.master    bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OP_W-1:0]     r_op;
  logic [OP_W-1:0]     w_ir_op;
  logic                w_unused_ir;

  logic                w_go;
  logic                w_continue;
  logic                w_first;
  logic                w_expired;
  logic                w_tmr_clr;
  logic                w_tmr_en;

  logic [2:0]          w_bus_src;
  logic [1:0]          w_reg_sel;
  logic [c_ld_w-1:0]   w_ld;
  logic                w_inc_pc;
  logic                w_mem_read;
  logic [OP_W-1:0]     w_alu_op;
  logic                w_alu_start;
  logic                w_instr_done;
  logic                w_illegal;
  logic                w_timeout;

  assign w_ir_op     = bus.ir[31 -: OP_W];
  assign w_unused_ir = ^bus.ir[31-OP_W:0];

`ifdef SINGLE_STEP_EN
  // A step launch is remembered so the instruction ends in IDLE even if run=1.
  logic r_single;

  assign w_go       = bus.run | bus.step;
  assign w_continue = bus.run & ~r_single;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_single <= 1'b0;
    end else if ((r_state == S_IDLE) && w_go) begin
      r_single <= bus.step;
    end
  end
`else
  assign w_go       = bus.run;
  assign w_continue = bus.run;
`endif

  // Counter is held clear outside the two wait states, so it reads 0 on entry.
  assign w_tmr_clr = (r_state != S_T1) && (r_state != S_T4);

  ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clock   (clock),
    .clear_n (clear_n),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .first   (w_first),
    .expired (w_expired)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_T3) begin
        r_op <= w_ir_op;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bus_src    = c_bus_none;
    w_reg_sel    = c_reg_none;
    w_ld         = '0;
    w_inc_pc     = 1'b0;
    w_mem_read   = 1'b0;
    w_alu_op     = '0;
    w_alu_start  = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    w_timeout    = 1'b0;
    w_tmr_en     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_T0;
        end
      end

      S_T0: begin
        w_bus_src        = c_bus_pc;
        w_ld[c_ld_mar]   = 1'b1;
        w_ld[c_ld_z]     = 1'b1;
        w_inc_pc         = 1'b1;
        w_state_nxt      = S_T1;
      end

      S_T1: begin
        w_bus_src  = c_bus_zlo;
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ld[c_ld_mdr] = 1'b1;
          w_ld[c_ld_pc]  = w_first;
          w_state_nxt    = S_T2;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_ld[c_ld_pc] = w_first;
          w_tmr_en      = 1'b1;
        end
      end

      S_T2: begin
        w_bus_src     = c_bus_mdr;
        w_ld[c_ld_ir] = 1'b1;
        w_state_nxt   = S_T3;
      end

      S_T3: begin
        if (!op_is_legal(w_ir_op)) begin
          w_illegal   = 1'b1;
          w_state_nxt = w_continue ? S_T0 : S_IDLE;
        end else if (op_is_unary(w_ir_op)) begin
          w_bus_src    = c_bus_reg;
          w_reg_sel    = c_reg_rb;
          w_alu_op     = w_ir_op;
          w_ld[c_ld_z] = 1'b1;
          w_state_nxt  = S_T5;
        end else begin
          w_bus_src    = c_bus_reg;
          w_reg_sel    = c_reg_rb;
          w_ld[c_ld_y] = 1'b1;
          w_state_nxt  = S_T4;
        end
      end

      S_T4: begin
        w_bus_src = c_bus_reg;
        w_reg_sel = c_reg_rc;
        w_alu_op  = r_op;
        if (op_is_muldiv(r_op)) begin
          w_alu_start = w_first;
          if (bus.alu_done) begin
            w_ld[c_ld_z] = 1'b1;
            w_state_nxt  = S_T5;
          end else if (w_expired) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_tmr_en = 1'b1;
          end
        end else begin
          w_ld[c_ld_z] = 1'b1;
          w_state_nxt  = S_T5;
        end
      end

      S_T5: begin
        w_bus_src = c_bus_zlo;
        if (op_is_muldiv(r_op)) begin
          w_ld[c_ld_lo] = 1'b1;
          w_state_nxt   = S_T6;
        end else begin
          w_reg_sel     = c_reg_ra;
          w_ld[c_ld_r]  = 1'b1;
          w_instr_done  = 1'b1;
          w_state_nxt   = w_continue ? S_T0 : S_IDLE;
        end
      end

      S_T6: begin
        w_bus_src     = c_bus_zhi;
        w_ld[c_ld_hi] = 1'b1;
        w_instr_done  = 1'b1;
        w_state_nxt   = w_continue ? S_T0 : S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.bus_src    = w_bus_src;
  assign bus.reg_sel    = w_reg_sel;
  assign bus.ld         = w_ld;
  assign bus.inc_pc     = w_inc_pc;
  assign bus.mem_read   = w_mem_read;
  assign bus.alu_op     = w_alu_op;
  assign bus.alu_start  = w_alu_start;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.instr_done = w_instr_done;
  assign bus.illegal_op = w_illegal;
  assign bus.timeout    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : self-checking bench for alu_seq_ctrl (default build, WAIT_MAX=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;

  localparam int WAIT_MAX = 8;

  localparam logic [2:0] c_b_none = 3'd0, c_b_pc = 3'd1, c_b_zlo = 3'd2,
                         c_b_zhi = 3'd3, c_b_mdr = 3'd4, c_b_reg = 3'd5;
  localparam logic [1:0] c_r_none = 2'd0, c_r_a = 2'd1, c_r_b = 2'd2, c_r_c = 2'd3;
  localparam logic [8:0] c_l_none = 9'h000, c_l_mar = 9'h001, c_l_z = 9'h002,
                         c_l_y = 9'h004, c_l_pc = 9'h008, c_l_mdr = 9'h010,
                         c_l_ir = 9'h020, c_l_r = 9'h040, c_l_lo = 9'h080,
                         c_l_hi = 9'h100;
  localparam logic [4:0] c_add = 5'b00011, c_mul = 5'b01111, c_div = 5'b10000,
                         c_not = 5'b10010, c_neg = 5'b10001, c_bad = 5'b11111;

  typedef struct packed {
    logic [2:0] bus_src;
    logic [1:0] reg_sel;
    logic [8:0] ld;
    logic       inc_pc;
    logic       mem_read;
    logic [4:0] alu_op;
    logic       alu_start;
    logic       busy;
    logic       instr_done;
    logic       illegal_op;
    logic       timeout;
  } outv_t;

  typedef struct {
    logic        rn;
    logic        mr;
    logic        ad;
    logic [31:0] ir;
    outv_t       exp;
  } cyc_t;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  alu_seq_ctrl_if #(.OP_W(5)) bus ();

  alu_seq_ctrl #(
    .WAIT_MAX (WAIT_MAX),
    .OP_W     (5)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  logic [4:0] legal_ops [13] = '{5'b01011, 5'b01010, 5'b10010, 5'b00011, 5'b00100,
                                 5'b01111, 5'b10000, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01001, 5'b10001};

  cyc_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   model_idle;
  int   cnt_busy, cnt_pc, cnt_start, cnt_to, cnt_ill, cnt_done;

  function automatic bit is_legal(input logic [4:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic outv_t mk(input logic [2:0] bs, input logic [1:0] rs,
                               input logic [8:0] ldv, input logic inc,
                               input logic mr, input logic [4:0] op,
                               input logic st, input logic dn,
                               input logic il, input logic to);
    outv_t o;
    o.bus_src = bs;   o.reg_sel = rs;   o.ld = ldv;      o.inc_pc = inc;
    o.mem_read = mr;  o.alu_op = op;    o.alu_start = st; o.busy = 1'b1;
    o.instr_done = dn; o.illegal_op = il; o.timeout = to;
    return o;
  endfunction

  function automatic outv_t sample();
    return {bus.bus_src, bus.reg_sel, bus.ld, bus.inc_pc, bus.mem_read, bus.alu_op,
            bus.alu_start, bus.busy, bus.instr_done, bus.illegal_op, bus.timeout};
  endfunction

  task automatic push(input logic rn, input logic mr, input logic ad,
                      input logic [31:0] irv, input outv_t e);
    cyc_t c;
    c.rn = rn; c.mr = mr; c.ad = ad; c.ir = irv; c.exp = e;
    q.push_back(c);
  endtask

  task automatic idle_cycle();
    push(1'b0, 1'b0, 1'b0, 32'h0, '0);
  endtask

  // Expected cycle trace of one instruction: lm = T1 cycle in which memory
  // answers, la = T4 cycle in which MUL/DIV answers, rn = run level throughout.
  task automatic model_instr(input logic [4:0] op, input logic [26:0] lo,
                             input int lm, input int la, input logic rn);
    logic [31:0] irv;
    bit          md, un;
    irv = {op, lo};
    md  = (op == c_mul) || (op == c_div);
    un  = (op == c_not) || (op == c_neg);
    if (model_idle) push(1'b1, 1'b0, 1'b0, irv, '0);
    model_idle = !rn;
    push(rn, 1'b0, 1'b0, irv, mk(c_b_pc, c_r_none, c_l_mar | c_l_z, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 1000; k++) begin
      if (k == lm) begin
        push(rn, 1'b1, 1'b0, irv, mk(c_b_zlo, c_r_none, (k == 0) ? (c_l_mdr | c_l_pc) : c_l_mdr,
                                     1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        break;
      end
      if (k == WAIT_MAX - 1) begin
        push(rn, 1'b0, 1'b0, irv, mk(c_b_zlo, c_r_none, c_l_none, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        model_idle = 1'b1;
        return;
      end
      push(rn, 1'b0, 1'b0, irv, mk(c_b_zlo, c_r_none, (k == 0) ? c_l_pc : c_l_none,
                                   1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    push(rn, 1'b0, 1'b0, irv, mk(c_b_mdr, c_r_none, c_l_ir, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (!is_legal(op)) begin
      push(rn, 1'b0, 1'b0, irv, mk(c_b_none, c_r_none, c_l_none, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      return;
    end
    if (un) begin
      push(rn, 1'b0, 1'b0, irv, mk(c_b_reg, c_r_b, c_l_z, 1'b0, 1'b0, op, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      push(rn, 1'b0, 1'b0, irv, mk(c_b_reg, c_r_b, c_l_y, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      if (md) begin
        for (int k = 0; k < 1000; k++) begin
          if (k == la) begin
            push(rn, 1'b0, 1'b1, irv, mk(c_b_reg, c_r_c, c_l_z, 1'b0, 1'b0, op, k == 0, 1'b0, 1'b0, 1'b0));
            break;
          end
          if (k == WAIT_MAX - 1) begin
            push(rn, 1'b0, 1'b0, irv, mk(c_b_reg, c_r_c, c_l_none, 1'b0, 1'b0, op, k == 0, 1'b0, 1'b0, 1'b1));
            model_idle = 1'b1;
            return;
          end
          push(rn, 1'b0, 1'b0, irv, mk(c_b_reg, c_r_c, c_l_none, 1'b0, 1'b0, op, k == 0, 1'b0, 1'b0, 1'b0));
        end
      end else begin
        push(rn, 1'b0, 1'b0, irv, mk(c_b_reg, c_r_c, c_l_z, 1'b0, 1'b0, op, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
    if (md) begin
      push(rn, 1'b0, 1'b0, irv, mk(c_b_zlo, c_r_none, c_l_lo, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      push(rn, 1'b0, 1'b0, irv, mk(c_b_zhi, c_r_none, c_l_hi, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    end else begin
      push(rn, 1'b0, 1'b0, irv, mk(c_b_zlo, c_r_a, c_l_r, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic chkv(input string tag, input outv_t obs, input outv_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1; checks each cycle on the falling edge.
  task automatic flush(input string tag);
    cyc_t  c;
    outv_t o;
    int    idx;
    cnt_busy = 0; cnt_pc = 0; cnt_start = 0; cnt_to = 0; cnt_ill = 0; cnt_done = 0;
    idx = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.run = c.rn; bus.ir = c.ir; bus.mem_ready = c.mr; bus.alu_done = c.ad;
      @(negedge clock);
      o = sample();
      chkv($sformatf("%s_cyc%0d", tag, idx), o, c.exp);
      cnt_busy  += int'(o.busy);
      cnt_pc    += int'(o.ld[3]);
      cnt_start += int'(o.alu_start);
      cnt_to    += int'(o.timeout);
      cnt_ill   += int'(o.illegal_op);
      cnt_done  += int'(o.instr_done);
      idx++;
      @(posedge clock);
      #1;
    end
    bus.mem_ready = 1'b0;
    bus.alu_done  = 1'b0;
  endtask

  initial begin
    logic [4:0] op;
    int         lm, la;
    logic       rn;

    bus.run = 1'b0; bus.ir = 32'h0; bus.mem_ready = 1'b0; bus.alu_done = 1'b0;
    #2;
    chkv("reset_outputs", sample(), '0);
    bus.run = 1'b1;
    @(posedge clock); #1;
    chkv("reset_hold_run", sample(), '0);
    bus.run = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock); #1;
    model_idle = 1'b1;

    model_instr(c_add, 27'h2000000, 0, 0, 1'b0);
    idle_cycle();
    flush("add");
    chki("add_busy_cycles", cnt_busy, 6);
    chki("add_done_pulses", cnt_done, 1);

    model_instr(c_mul, 27'($urandom), 0, 5, 1'b0);
    idle_cycle();
    flush("mul");
    chki("mul_busy_cycles", cnt_busy, 12);
    chki("mul_start_pulses", cnt_start, 1);

    model_instr(c_not, 27'($urandom), 3, 0, 1'b0);
    idle_cycle();
    flush("not_late_mem");
    chki("not_pc_in_pulses", cnt_pc, 1);
    chki("not_busy_cycles", cnt_busy, 8);

    model_instr(c_bad, 27'($urandom), 0, 0, 1'b1);
    model_instr(c_add, 27'($urandom), 0, 0, 1'b0);
    idle_cycle();
    flush("illegal");
    chki("illegal_pulses", cnt_ill, 1);

    model_instr(c_add, 27'($urandom), 100, 0, 1'b1);
    idle_cycle();
    flush("mem_timeout");
    chki("mem_timeout_pulses", cnt_to, 1);
    chki("mem_timeout_busy", cnt_busy, 1 + WAIT_MAX);

    model_instr(c_add, 27'($urandom), WAIT_MAX - 1, 0, 1'b0);
    model_instr(c_div, 27'($urandom), 0, WAIT_MAX - 1, 1'b0);
    idle_cycle();
    flush("ready_wins");
    chki("ready_wins_timeouts", cnt_to, 0);

    model_instr(c_div, 27'($urandom), 0, 100, 1'b0);
    idle_cycle();
    flush("alu_timeout");
    chki("alu_timeout_pulses", cnt_to, 1);
    chki("alu_timeout_busy", cnt_busy, 4 + WAIT_MAX);

    // Abort a MUL while it waits for the multiplier.
    bus.run = 1'b1; bus.ir = {c_mul, 27'h0}; bus.mem_ready = 1'b1; bus.alu_done = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    @(negedge clock);
    chkv("mul_wait_before_reset", sample(),
         mk(c_b_reg, c_r_c, c_l_none, 1'b0, 1'b0, c_mul, 1'b0, 1'b0, 1'b0, 1'b0));
    #2;
    clear_n  = 1'b0;
    bus.run  = 1'b0;
    #1;
    chkv("reset_async_mid_instr", sample(), '0);
    @(posedge clock); #1;
    chkv("reset_held_mid_instr", sample(), '0);
    bus.mem_ready = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock); #1;
    model_idle = 1'b1;
    model_instr(c_neg, 27'($urandom), 1, 0, 1'b0);
    idle_cycle();
    flush("after_reset");

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 7) == 0) op = 5'($urandom);
      else op = legal_ops[$urandom_range(0, 12)];
      lm = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
      la = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 6));
      rn = ($urandom_range(0, 3) != 0);
      model_instr(op, 27'($urandom), lm, la, rn);
    end
    model_instr(c_add, 27'($urandom), 0, 0, 1'b0);
    idle_cycle();
    flush("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle control sequencer for the single-bus datapath and its ALU. It fetches each instruction and decodes IR[31:27], then steps the datapath through T0..T6. It drives bus-source selects, register load strobes and the ALU opcode, and waits on memory and multi-cycle MUL/DIV handshakes. It sits between the IR and the datapath as the execute engine for ALU-class instructions.

Parameters:
WAIT_MAX, 64, max cycles spent in a wait state (memory or ALU) before timeout abort
OP_W, 5, opcode field width (IR[31:27])

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep fetching instructions
ir  in  32  current IR contents; opcode = ir[31:27]
mem_ready  in  1  memory read data valid this cycle
alu_done  in  1  MUL/DIV result valid this cycle
bus_src  out  3  0 none, 1 PC, 2 ZLO, 3 ZHI, 4 MDR, 5 REG
reg_sel  out  2  0 none, 1 Ra, 2 Rb, 3 Rc (IR field select)
ld  out  9  load strobes {hi_in,lo_in,r_in,ir_in,mdr_in,pc_in,y_in,z_in,mar_in}, bit 0 = mar_in
inc_pc  out  1  ALU computes PC+1 into Z
mem_read  out  1  memory read request
alu_op  out  5  opcode to ALU (0 when not executing)
alu_start  out  1  one-cycle pulse launching MUL/DIV
busy  out  1  state != IDLE
instr_done  out  1  one-cycle pulse in final state of instruction
illegal_op  out  1  one-cycle pulse on undecodable opcode
timeout  out  1  one-cycle pulse on wait abort

Behaviour:
- States: IDLE, T0..T6. Outputs decode from registered state; mdr_in, z_in (in T4) and the wait exits also depend on mem_ready/alu_done in the same cycle.
- Reset (clear_n=0, async): state=IDLE, wait counter=0, latched opcode=0; all outputs 0 immediately. Reset mid-instruction aborts with no further strobes.
- IDLE: all outputs 0; run=1 -> T0.
- T0: bus_src=PC, mar_in, inc_pc, z_in -> T1.
- T1: bus_src=ZLO, pc_in on first cycle only, mem_read held. mdr_in in the cycle mem_ready=1, then -> T2. Otherwise stay.
- T2: bus_src=MDR, ir_in -> T3.
- T3: latch op_q=ir[31:27]. Legal opcodes: OR 01011, AND 01010, NOT 10010, ADD 00011, SUB 00100, MUL 01111, DIV 10000, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, NEG 10001.
  - Illegal: illegal_op pulse, no loads -> T0 if run else IDLE.
  - NOT/NEG: bus_src=REG, reg_sel=Rb, alu_op=op, z_in -> T5.
  - Others: bus_src=REG, reg_sel=Rb, y_in -> T4.
- T4: bus_src=REG, reg_sel=Rc, alu_op=op_q.
  - Non-MUL/DIV: z_in -> T5.
  - MUL/DIV: alu_start on the first T4 cycle only. Hold until alu_done=1, assert z_in that cycle -> T5. alu_done on the first cycle is accepted.
- T5: bus_src=ZLO. MUL/DIV: lo_in -> T6. Else reg_sel=Ra, r_in, instr_done -> next.
- T6: bus_src=ZHI, hi_in, instr_done -> next.
- next = T0 if run else IDLE. Deasserting run never truncates an instruction.
- Wait counter: cleared on entry to T1 or T4, increments each waiting cycle. On reaching WAIT_MAX-1 without ready: timeout pulse -> IDLE with no load that cycle. A ready arriving in that same cycle wins.
- At most one bus_src per cycle. ld bits other than those listed are 0.

Optional Feature:
SINGLE_STEP_EN: adds input step (1 bit). In IDLE, a step=1 cycle starts exactly one instruction, which then returns to IDLE regardless of run; step is ignored while busy. Without the macro: no step port; only run starts execution.

Decomposition:
- Package cpu_ctrl_pkg: opcode constants, state enum, bus_src codes, reg_sel codes, ld bit index constants.
- Sub-module ctrl_wait_timer: clear/enable/expired counter parameterised by WAIT_MAX, shared by the T1 and T4 waits.

Test Plan:
- ir=0x1A000000 (ADD), mem_ready in first T1 cycle, run=1 then 0 -> T0..T5 in 6 cycles; y_in in T3, z_in in T4, r_in+instr_done in T5, then IDLE.
- MUL (ir[31:27]=01111), alu_done 5 cycles after alu_start -> single alu_start pulse; z_in coincident with alu_done; lo_in in T5, hi_in in T6; 12 cycles total.
- NOT (10010) with mem_ready 3 cycles late -> mdr_in in 4th T1 cycle, pc_in only once; T4 skipped; z_in in T3.
- Opcode 11111 -> illegal_op pulse in T3, zero load strobes, back to T0.
- mem_ready held 0, WAIT_MAX=8 -> timeout pulse after 8 T1 cycles, IDLE, busy=0.
- clear_n low during MUL T4 wait -> all outputs 0 immediately; after release with run=1, fetch restarts at T0.
